// File: rtl/btn_event_decoder.sv
// btn_event_decoder
//   Turns the debounced button level into user-interface events: short press,
//   long press and double press, plus press/release edge strobes, a registered
//   copy of the level and a wrapping count of classified events.
//   All timing is in cycles of clk.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   db_in         in   debounced button level
//   enable        in   low holds the decoder idle and suppresses every strobe
//   press_pulse   out  one-cycle strobe on a debounced rising edge
//   release_pulse out  one-cycle strobe on a debounced falling edge
//   short_press   out  one-cycle strobe: single short press confirmed
//   long_press    out  one-cycle strobe: hold reached LONG_CNT cycles
//   double_press  out  one-cycle strobe: second press started inside the gap
//   held          out  registered copy of db_in
//   event_count   out  count of short/long/double events, wraps 255 -> 0
module btn_event_decoder #(
  parameter int LONG_CNT = 100_000_000,
  parameter int GAP_CNT  = 25_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_in,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_LONG_HOLD,
    S_WAIT2,
    S_WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_prev_q;
  logic             held_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic [7:0]       event_count_q, event_count_d;

  logic rise;
  logic fall;

  // Edges are taken against the previous sampled level, which keeps tracking
  // db_in even while disabled so re-enabling mid-hold yields no false rise.
  assign rise = db_in & ~db_prev_q;
  assign fall = ~db_in & db_prev_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    short_d       = 1'b0;
    long_d        = 1'b0;
    double_d      = 1'b0;
    press_d       = rise & enable;
    release_d     = fall & enable;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_PRESS1;
            cnt_d   = '0;
          end
        end
        S_PRESS1: begin
          // A release on the very last hold cycle still counts as short.
          if (fall) begin
            state_d = S_WAIT2;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = S_LONG_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_LONG_HOLD: begin
          if (fall) state_d = S_IDLE;
        end
        S_WAIT2: begin
          // A re-press on the last gap cycle still counts as double.
          if (rise) begin
            double_d = 1'b1;
            state_d  = S_WAIT_REL;
          end else if (cnt_q == GAP_LAST) begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (fall) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    event_count_d = event_count_q + {7'd0, short_d | long_d | double_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      db_prev_q     <= 1'b0;
      held_q        <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      double_q      <= 1'b0;
      event_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      db_prev_q     <= db_in;
      held_q        <= db_in;
      press_q       <= press_d;
      release_q     <= release_d;
      short_q       <= short_d;
      long_q        <= long_d;
      double_q      <= double_d;
      event_count_q <= event_count_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_press  = double_q;
  assign held          = held_q;
  assign event_count   = event_count_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_CNT=20, GAP_CNT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so after tick() the outputs reflect the edge just taken.
module tb_btn_event_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       db_in = 1'b0;
  logic       enable = 1'b1;
  logic       press_pulse, release_pulse, short_press, long_press, double_press, held;
  logic [7:0] event_count;

  int errors = 0;
  int checks = 0;
  int n_press = 0, n_rel = 0, n_short = 0, n_long = 0, n_dbl = 0;

  btn_event_decoder #(.LONG_CNT(20), .GAP_CNT(8), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .db_in        (db_in),
    .enable       (enable),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_short += int'(short_press);
    n_long  += int'(long_press);
    n_dbl   += int'(double_press);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_dbl = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    db_in  = 1'b0;
    enable = 1'b1;
    reset  = 1'b1;
    ticks(2);
    reset  = 1'b0;
    clr();
  endtask

  initial begin
    // 1: reset with the button held, then db_prev catches up with one press.
    db_in = 1'b1;
    reset = 1'b1;
    ticks(2);
    chk("rst_outputs", int'({press_pulse, release_pulse, short_press, long_press, double_press, held}), 0);
    chk("rst_count", int'(event_count), 0);
    reset = 1'b0;
    clr();
    tick();
    chk("s1_first_press", int'(press_pulse), 1);
    chk("s1_held", int'(held), 1);
    ticks(5);
    chk("s1_one_press", n_press, 1);
    db_in = 1'b0;
    tick();
    chk("s1_release", int'(release_pulse), 1);
    ticks(10);
    db_in = 1'b1;
    tick();
    chk("s1_second_press", int'(press_pulse), 1);

    // 2: short press, short_press 8 edges after the fall edge.
    do_reset();
    db_in = 1'b1;
    tick();
    chk("s2_press", int'(press_pulse), 1);
    ticks(4);
    db_in = 1'b0;
    tick();
    chk("s2_release", int'(release_pulse), 1);
    ticks(7);
    chk("s2_short_early", n_short, 0);
    tick();
    chk("s2_short", int'(short_press), 1);
    chk("s2_count", int'(event_count), 1);
    tick();
    chk("s2_short_once", int'(short_press), 0);
    chk("s2_no_long_dbl", n_long + n_dbl, 0);

    // 3: long press, long_press 20 edges after the rise edge.
    do_reset();
    db_in = 1'b1;
    tick();
    ticks(19);
    chk("s3_long_early", n_long, 0);
    tick();
    chk("s3_long", int'(long_press), 1);
    tick();
    chk("s3_long_once", int'(long_press), 0);
    ticks(8);
    db_in = 1'b0;
    tick();
    chk("s3_release", int'(release_pulse), 1);
    ticks(20);
    chk("s3_no_short", n_short, 0);
    chk("s3_long_total", n_long, 1);
    chk("s3_count", int'(event_count), 1);

    // 3b: release sampled exactly when the hold would time out -> short.
    do_reset();
    db_in = 1'b1;
    ticks(20);
    db_in = 1'b0;
    tick();
    chk("s3b_no_long", int'(long_press), 0);
    ticks(8);
    chk("s3b_short", int'(short_press), 1);
    chk("s3b_long_total", n_long, 0);

    // 4: double press.
    do_reset();
    db_in = 1'b1;
    ticks(4);
    db_in = 1'b0;
    ticks(3);
    db_in = 1'b1;
    tick();
    chk("s4_double", int'(double_press), 1);
    chk("s4_count", int'(event_count), 1);
    ticks(3);
    db_in = 1'b0;
    ticks(21);
    chk("s4_no_short", n_short, 0);
    chk("s4_dbl_total", n_dbl, 1);

    // 4b: re-press sampled when the gap would time out -> double, not short.
    do_reset();
    db_in = 1'b1;
    ticks(3);
    db_in = 1'b0;
    ticks(8);
    chk("s4b_short_early", n_short, 0);
    db_in = 1'b1;
    tick();
    chk("s4b_double", int'(double_press), 1);
    chk("s4b_short_now", int'(short_press), 0);
    ticks(2);
    db_in = 1'b0;
    ticks(21);
    chk("s4b_no_short", n_short, 0);
    chk("s4b_count", int'(event_count), 1);

    // 5: enable dropped mid-hold, re-enabled while held, then release.
    do_reset();
    db_in = 1'b1;
    tick();
    ticks(9);
    enable = 1'b0;
    ticks(5);
    chk("s5_held_dis", int'(held), 1);
    enable = 1'b1;
    ticks(12);
    chk("s5_no_repress", n_press, 1);
    chk("s5_no_rel_yet", n_rel, 0);
    db_in = 1'b0;
    tick();
    chk("s5_release", int'(release_pulse), 1);
    ticks(30);
    chk("s5_no_events", n_short + n_long + n_dbl, 0);
    chk("s5_count", int'(event_count), 0);

    // 5b: release while disabled gives no release_pulse.
    do_reset();
    db_in = 1'b1;
    ticks(3);
    enable = 1'b0;
    tick();
    db_in = 1'b0;
    ticks(3);
    chk("s5b_no_rel", n_rel, 0);
    chk("s5b_held", int'(held), 0);
    enable = 1'b1;

    // 6: reset inside WAIT2 discards the pending short; then count wrap.
    do_reset();
    db_in = 1'b1;
    ticks(3);
    db_in = 1'b0;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    chk("s6_rst_count", int'(event_count), 0);
    ticks(15);
    chk("s6_no_short", n_short, 0);
    for (int i = 0; i < 255; i++) begin
      db_in = 1'b1;
      ticks(2);
      db_in = 1'b0;
      ticks(10);
    end
    chk("s6_count_255", int'(event_count), 255);
    db_in = 1'b1;
    ticks(2);
    db_in = 1'b0;
    ticks(10);
    chk("s6_wrap", int'(event_count), 0);
    chk("s6_short_total", n_short, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
